// File: rtl/dmem_req_scheduler.sv
// -----------------------------------------------------------------------------
// dmem_req_scheduler
//
// Purpose:
//   Sequences the single data-side memory port used by the MEM stage. It
//   arbitrates between pipeline load/store requests and CACHE-instruction
//   operations, tracks accepted-but-unanswered requests for the
//   addr_ok/data_ok handshake, and drops responses that belong to
//   instructions flushed by an exception or eret.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             CP0 exception/eret flush
//   ls_*              load/store request side (MEM stage)
//   ls_addr_ok        load/store accepted this cycle
//   ls_data_ok        load/store response valid, data on ls_rdata
//   ci_*              cache-instruction request, held until ci_done
//   ci_done           one-cycle pulse when the cache op completes
//   data_*            downstream port to the dcache / uncached bridge
//   busy              FSM not idle, or requests still outstanding
// -----------------------------------------------------------------------------
module dmem_req_scheduler #(
    parameter int MAX_OUT    = 2,
    parameter int CACHE_OP_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_addr,
    input  logic [31:0]           ls_wdata,
    input  logic [3:0]            ls_wstrb,
    output logic                  ls_addr_ok,
    output logic                  ls_data_ok,
    output logic [31:0]           ls_rdata,

    input  logic                  ci_req,
    input  logic [CACHE_OP_W-1:0] ci_op,
    input  logic [31:0]           ci_addr,
    output logic                  ci_done,

    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [31:0]           data_addr,
    output logic [31:0]           data_wdata,
    output logic [3:0]            data_wstrb,
    output logic                  data_cacheop,
    output logic [CACHE_OP_W-1:0] data_op,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,

    output logic                  busy
);

    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_CI_ISSUE,
        S_CI_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_outstanding;
    logic [CW-1:0]           w_outstanding_nxt;
    logic [CW-1:0]           r_discard;
    logic [CW-1:0]           w_discard_nxt;

    logic                    w_req;
    logic                    w_wr;
    logic [1:0]              w_size;
    logic [31:0]             w_addr;
    logic [31:0]             w_wdata;
    logic [3:0]              w_wstrb;
    logic                    w_cacheop;
    logic [CACHE_OP_W-1:0]   w_op;
    logic                    w_ci_done;
    logic                    w_accept;
    logic                    w_ls_data_ok;

    // ------------------------------------------------------------------
    // Next-state and downstream request generation
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned (latch).
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_wr        = 1'b0;
        w_size      = 2'd0;
        w_addr      = 32'd0;
        w_wdata     = 32'd0;
        w_wstrb     = 4'd0;
        w_cacheop   = 1'b0;
        w_op        = '0;
        w_ci_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Full check uses the registered count only: a response in
                // the same cycle does not free a slot until the next cycle.
                w_req   = ls_req & ~ci_req & ~flush & (r_outstanding < MAX_CNT);
                w_wr    = ls_wr;
                w_size  = ls_size;
                w_addr  = ls_addr;
                w_wdata = ls_wdata;
                w_wstrb = ls_wstrb;
                if (ci_req && !flush) begin
                    if ((r_outstanding != '0) || (w_req && data_addr_ok))
                        w_state_nxt = S_DRAIN;
                    else
                        w_state_nxt = S_CI_ISSUE;
                end
            end

            S_DRAIN: begin
                // Flush kills the CACHE instruction before it was issued.
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (r_outstanding == '0)
                    w_state_nxt = S_CI_ISSUE;
            end

            S_CI_ISSUE: begin
                // The op is committed once here; flush does not abort it.
                w_req     = 1'b1;
                w_cacheop = 1'b1;
                w_op      = ci_op;
                w_addr    = ci_addr;
                w_size    = 2'd2;
                if (data_addr_ok)
                    w_state_nxt = S_CI_WAIT;
            end

            S_CI_WAIT: begin
                if (data_data_ok) begin
                    w_ci_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept     = w_req & data_addr_ok;
    assign w_ls_data_ok = data_data_ok & (r_discard == '0) & (r_state != S_CI_WAIT);

    // ------------------------------------------------------------------
    // In-flight and discard accounting
    // ------------------------------------------------------------------
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accept && !data_data_ok)
            w_outstanding_nxt = r_outstanding + ONE;
        else if (!w_accept && data_data_ok)
            w_outstanding_nxt = r_outstanding - ONE;

        // On flush every request still in flight after this cycle belongs to
        // a squashed instruction; that is exactly the next outstanding count.
        // Recomputing (not adding) keeps back-to-back flushes from doubling.
        w_discard_nxt = r_discard;
        if (flush)
            w_discard_nxt = w_outstanding_nxt;
        else if (data_data_ok && (r_discard != '0))
            w_discard_nxt = r_discard - ONE;
    end

    // NOTE: async reset in the sensitivity list; state updates use
    // non-blocking assignments so all registers sample the same old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: several paths are combinational from inputs, so they are
    // forced low while reset is held to keep the port quiet immediately.
    // ------------------------------------------------------------------
    assign data_req     = ~rst & w_req;
    assign data_wr      = ~rst & w_wr;
    assign data_size    = rst ? 2'd0  : w_size;
    assign data_addr    = rst ? 32'd0 : w_addr;
    assign data_wdata   = rst ? 32'd0 : w_wdata;
    assign data_wstrb   = rst ? 4'd0  : w_wstrb;
    assign data_cacheop = ~rst & w_cacheop;
    assign data_op      = rst ? '0 : w_op;

    assign ls_addr_ok   = ~rst & w_accept & (r_state == S_IDLE);
    assign ls_data_ok   = ~rst & w_ls_data_ok;
    assign ls_rdata     = rst ? 32'd0 : data_rdata;
    assign ci_done      = ~rst & w_ci_done;
    assign busy         = ~rst & ((r_state != S_IDLE) | (r_outstanding != '0));

endmodule

// File: tb/tb_dmem_req_scheduler.sv
`timescale 1ns/1ps
module tb_dmem_req_scheduler;

  localparam int MAX_OUT = 2;
  localparam int OPW     = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            ls_req, ls_wr;
  logic [1:0]      ls_size;
  logic [31:0]     ls_addr, ls_wdata;
  logic [3:0]      ls_wstrb;
  logic            ls_addr_ok, ls_data_ok;
  logic [31:0]     ls_rdata;
  logic            ci_req;
  logic [OPW-1:0]  ci_op;
  logic [31:0]     ci_addr;
  logic            ci_done;
  logic            data_req, data_wr;
  logic [1:0]      data_size;
  logic [31:0]     data_addr, data_wdata;
  logic [3:0]      data_wstrb;
  logic            data_cacheop;
  logic [OPW-1:0]  data_op;
  logic            data_addr_ok, data_data_ok;
  logic [31:0]     data_rdata;
  logic            busy;

  dmem_req_scheduler #(.MAX_OUT(MAX_OUT), .CACHE_OP_W(OPW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_addr_ok(ls_addr_ok), .ls_data_ok(ls_data_ok), .ls_rdata(ls_rdata),
    .ci_req(ci_req), .ci_op(ci_op), .ci_addr(ci_addr), .ci_done(ci_done),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_cacheop(data_cacheop), .data_op(data_op),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an in-order list of in-flight requests, each tagged as
  // a cache op or a load/store, and whether its instruction was squashed.
  typedef struct packed { bit is_ci; bit dropped; } ent_t;
  ent_t q[$];

  // Progress of the current CACHE instruction.
  localparam int CI_NONE  = 0;  // no cache op in progress
  localparam int CI_DRAIN = 1;  // waiting for older requests to return
  localparam int CI_SEND  = 2;  // presenting the op downstream
  localparam int CI_RESP  = 3;  // op accepted, waiting for its response
  int  ci_phase = CI_NONE;
  bit  drop_ci  = 0;

  task automatic idle_inputs();
    flush = 0; ls_req = 0; ls_wr = 0; ls_size = 0; ls_addr = 0; ls_wdata = 0;
    ls_wstrb = 0; ci_req = 0; ci_op = 0; ci_addr = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance the model.
  task automatic cycle(input int p_ls, input int p_aok, input int p_dok,
                       input int p_ci, input int p_fl);
    int  n, old_phase;
    bit  e_req, e_aok, e_dok, e_done, accept;
    @(negedge clk);
    if (drop_ci) begin ci_req = 0; drop_ci = 0; end
    ls_req   = ($urandom_range(99) < p_ls);
    ls_wr    = 1'($urandom);
    ls_size  = 2'($urandom_range(2));
    ls_addr  = $urandom;
    ls_wdata = $urandom;
    ls_wstrb = 4'($urandom);
    if (!ci_req && ($urandom_range(99) < p_ci)) begin
      ci_req  = 1;
      ci_op   = OPW'($urandom);
      ci_addr = $urandom;
    end
    flush        = ($urandom_range(99) < p_fl);
    data_addr_ok = ($urandom_range(99) < p_aok);
    data_data_ok = (q.size() != 0) && ($urandom_range(99) < p_dok);
    data_rdata   = $urandom;
    #1;

    n      = q.size();
    e_req  = 0;
    if (ci_phase == CI_NONE) e_req = ls_req && !ci_req && !flush && (n < MAX_OUT);
    if (ci_phase == CI_SEND) e_req = 1;
    e_aok  = (ci_phase == CI_NONE) && e_req && data_addr_ok;
    e_dok  = data_data_ok && (n != 0) && !q[0].dropped && !q[0].is_ci;
    e_done = (ci_phase == CI_RESP) && data_data_ok;

    check("data_req",     data_req,     e_req);
    check("ls_addr_ok",   ls_addr_ok,   e_aok);
    check("ls_data_ok",   ls_data_ok,   e_dok);
    check("ci_done",      ci_done,      e_done);
    check("data_cacheop", data_cacheop, (ci_phase == CI_SEND));
    check("busy",         busy,         (ci_phase != CI_NONE) || (n != 0));
    if (e_dok) check("ls_rdata", ls_rdata, data_rdata);
    if (ci_phase == CI_NONE && e_req) begin
      check("ls_addr_pass", data_addr,  ls_addr);
      check("ls_wr_pass",   data_wr,    ls_wr);
      check("ls_size_pass", data_size,  ls_size);
      check("ls_wdata_pass",data_wdata, ls_wdata);
      check("ls_wstrb_pass",data_wstrb, ls_wstrb);
    end
    if (ci_phase == CI_SEND) begin
      check("ci_addr_pass", data_addr, ci_addr);
      check("ci_op_pass",   data_op,   ci_op);
      check("ci_wr_zero",   data_wr,   1'b0);
    end

    // Advance the model to the values that hold after the coming posedge.
    accept    = e_req && data_addr_ok;
    old_phase = ci_phase;
    case (old_phase)
      CI_NONE:  if (ci_req && !flush) ci_phase = (n != 0 || accept) ? CI_DRAIN : CI_SEND;
      CI_DRAIN: if (flush) ci_phase = CI_NONE; else if (n == 0) ci_phase = CI_SEND;
      CI_SEND:  if (data_addr_ok) ci_phase = CI_RESP;
      CI_RESP:  if (data_data_ok) ci_phase = CI_NONE;
      default:  ci_phase = CI_NONE;
    endcase
    if (data_data_ok) void'(q.pop_front());
    if (accept) q.push_back('{is_ci: (old_phase == CI_SEND), dropped: 1'b0});
    if (flush) foreach (q[i]) q[i].dropped = 1'b1;

    // Bench stands in for the pipeline: a completed or squashed CACHE
    // instruction withdraws its request.
    if (e_done) drop_ci = 1;
    if (flush && ci_req && (old_phase == CI_NONE || old_phase == CI_DRAIN)) drop_ci = 1;
  endtask

  // Phase table: {p_ls, p_addr_ok, p_data_ok, p_ci, p_flush} in percent.
  int tab [4][5] = '{
    '{90, 100, 100,  0,  0},   // back-to-back loads/stores
    '{90, 100,  15,  5,  3},   // responses withheld: full condition
    '{70,  60,  50,  8,  8},   // mixed traffic
    '{60,  40,  40, 15, 15}    // heavy flush and cache-op traffic
  };

  initial begin
    idle_inputs();
    rst = 1;
    // Reset state: outputs quiet even with live-looking inputs.
    ls_req = 1; ls_addr = 32'hDEAD_BEEF; data_data_ok = 1; data_addr_ok = 1;
    data_rdata = 32'h1234_5678; ci_addr = 32'h8000_1000;
    #12;
    check("rst_data_req",   data_req,   1'b0);
    check("rst_ls_addr_ok", ls_addr_ok, 1'b0);
    check("rst_ls_data_ok", ls_data_ok, 1'b0);
    check("rst_ls_rdata",   ls_rdata,   32'd0);
    check("rst_data_addr",  data_addr,  32'd0);
    check("rst_busy",       busy,       1'b0);
    @(negedge clk);
    idle_inputs();
    rst = 0;

    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 1500; c++)
        cycle(tab[p][0], tab[p][1], tab[p][2], tab[p][3], tab[p][4]);

    // Drain everything, then walk a cache op into its response wait.
    begin
      int guard = 0;
      while ((ci_phase != CI_NONE || q.size() != 0 || (ci_req && !drop_ci)) && guard < 50) begin
        cycle(0, 100, 100, 0, 0);
        guard++;
      end
      check("drain_timeout", (guard < 50), 1'b1);
    end
    cycle(0, 0, 0, 100, 0);       // idle with no traffic: straight to issue
    cycle(0, 100, 0, 0, 0);       // op accepted: now awaiting its response
    check("ci_resp_reached", (ci_phase == CI_RESP), 1'b1);

    // Asynchronous reset in the middle of the cycle, response pending.
    @(negedge clk);
    if (drop_ci) begin ci_req = 0; drop_ci = 0; end
    ls_req = 1; ls_addr = 32'hCAFE_0000; data_addr_ok = 1;
    data_data_ok = 1; data_rdata = 32'hA5A5_A5A5;
    #1;
    check("pre_rst_ci_done", ci_done, 1'b1);
    #1 rst = 1;
    #1;
    check("arst_ci_done",   ci_done,      1'b0);
    check("arst_data_req",  data_req,     1'b0);
    check("arst_ls_data",   ls_data_ok,   1'b0);
    check("arst_ls_rdata",  ls_rdata,     32'd0);
    check("arst_cacheop",   data_cacheop, 1'b0);
    check("arst_busy",      busy,         1'b0);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    q.delete();
    ci_phase = CI_NONE;
    drop_ci  = 0;
    #1;
    check("post_rst_busy", busy, 1'b0);

    // Normal traffic resumes after reset.
    for (int c = 0; c < 200; c++) cycle(70, 70, 60, 5, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_req_scheduler.md
Name: dmem_req_scheduler

Overview:
- Sequences the single data-side memory port used by the MEM stage.
- Arbitrates between pipeline load/store requests and CACHE-instruction operations.
- Tracks in-flight requests for the addr_ok/data_ok handshake, and drops responses that belong to instructions flushed by an exception.
- Sits between MEM-stage request generation and the dcache/uncached bridge.

Parameters:
- MAX_OUT, 2, maximum accepted-but-unanswered requests (1..7).
- CACHE_OP_W, 5, width of the cache-operation code.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  CP0 exception/eret flush (same cycle as excOccur)
- ls_req  in  1  load/store request
- ls_wr  in  1  1 = store
- ls_size  in  2  0 = byte, 1 = half, 2 = word
- ls_addr  in  32  physical address
- ls_wdata  in  32  store data
- ls_wstrb  in  4  byte enables
- ls_addr_ok  out  1  load/store accepted this cycle
- ls_data_ok  out  1  load/store response valid
- ls_rdata  out  32  load data
- ci_req  in  1  cache-instruction request; held until ci_done
- ci_op  in  CACHE_OP_W  cache-op code
- ci_addr  in  32  cache-op address
- ci_done  out  1  one-cycle pulse: cache op completed
- data_req  out  1  downstream request
- data_wr  out  1  downstream write
- data_size  out  2  downstream size
- data_addr  out  32  downstream address
- data_wdata  out  32  downstream write data
- data_wstrb  out  4  downstream byte enables
- data_cacheop  out  1  qualifies data_req as a cache op
- data_op  out  CACHE_OP_W  cache-op code
- data_addr_ok  in  1  downstream accept
- data_data_ok  in  1  downstream response (in order)
- data_rdata  in  32  downstream read data
- busy  out  1  state != IDLE or outstanding != 0

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; outstanding = 0; discard = 0.
  - All outputs are 0 while reset is asserted.
  - Reset mid-transaction abandons everything; later stray data_data_ok is not the block's responsibility.
- Counters:
  - outstanding and discard are clog2(MAX_OUT+1) bits wide, saturation-free by construction.
  - outstanding: +1 on data_req & data_addr_ok; −1 on data_data_ok; unchanged when both occur in the same cycle.
- State machine IDLE / DRAIN / CI_ISSUE / CI_WAIT:
  - IDLE:
    - data_req = ls_req & !ci_req & !flush & (outstanding < MAX_OUT).
    - Load/store fields pass through combinationally; data_cacheop = 0.
    - ls_addr_ok = data_req & data_addr_ok.
    - If ci_req & !flush: go to DRAIN if outstanding != 0 or a handshake completes this cycle; otherwise go to CI_ISSUE.
  - DRAIN:
    - No new requests issued; ls_addr_ok = 0.
    - Go to CI_ISSUE when outstanding reaches 0.
    - flush returns to IDLE; the cache op is abandoned.
  - CI_ISSUE:
    - data_req = 1, data_cacheop = 1, data_op = ci_op, data_addr = ci_addr, data_wr = 0.
    - On data_addr_ok go to CI_WAIT.
    - flush is ignored here: the op is committed.
  - CI_WAIT:
    - On data_data_ok, pulse ci_done and go to IDLE.
    - The response is never forwarded to ls_data_ok.
- Responses:
  - ls_data_ok = data_data_ok & (discard == 0) & state != CI_WAIT.
  - ls_rdata = data_rdata.
  - When data_data_ok arrives with discard > 0: decrement discard and suppress ls_data_ok.
- Flush:
  - discard <= outstanding + (accept this cycle ? 1 : 0) − (data_data_ok this cycle ? 1 : 0).
  - data_req is forced to 0 in IDLE during the flush cycle.
  - Flush while discard > 0 recomputes discard the same way and does not accumulate.
- Full condition: outstanding == MAX_OUT blocks new requests, except in a cycle where data_data_ok is also asserted? No: the block uses registered outstanding only, with no same-cycle bypass.
- Latency:
  - Request path is zero-cycle combinational.
  - Cache op needs at least 2 cycles from ci_req, plus drain time.

Test Plan:
- Back-to-back loads, addr_ok always 1, data_ok 1 cycle later, rdata 0x11/0x22 → two ls_addr_ok, ls_data_ok returns 0x11 then 0x22; outstanding peaks at 1, back to 0.
- MAX_OUT=2, three loads, data_ok withheld → third load sees data_req=0 until the first data_ok; then accepted.
- Two loads outstanding, flush asserted → discard=2; next two data_data_ok produce no ls_data_ok; a new load after that returns normally.
- ci_req (op=5'h15, addr 0x8000_1000) with one load outstanding → DRAIN until data_ok, then CI_ISSUE; data_cacheop=1, data_op=0x15; after addr_ok and data_ok, ci_done pulses once; state returns to IDLE.
- ci_req in DRAIN plus flush → back to IDLE, no cacheop issued, ci_done stays 0.
- rst asserted mid-CI_WAIT (asynchronous) → all outputs 0 immediately, state IDLE, counters 0 after release.
